helm_rsp_tx: RTL
================

// Module: helm_rsp_tx
// PURPOSE
//  Response framer for the helm UART link; the return path of the helm message controller.
//  Triggers:
//   - tx_blkrd: fetches data_len bytes from user memory and frames them as a block-read response.
//   - tx_blkwr: frames a write acknowledge.
//  Bytes stream to the UART transmitter over a valid/ready byte interface.
// PARAMETERS
//  C_SYNC          8'hA5  first byte of every response frame
//  C_RSP_BLK_READ  8'h02  TYPE byte of block-read response
//  C_RSP_WR_ACK    8'h10  TYPE byte of block-write acknowledge
// PORTS
//  clk            in   1  clock
//  rst_b          in   1  reset, asynchronous, active-low
//  tx_blkrd       in   1  1-cycle pulse: start block-read response
//  tx_blkwr       in   1  1-cycle pulse: start write acknowledge
//  data_len       in   8  byte count, sampled with the trigger pulse
//  usr_mem_page   in   8  page, sampled with the trigger pulse
//  usr_mem_offset in   8  start offset, sampled with the trigger pulse
//  mem_rd_en      out  1  user memory read strobe
//  mem_rd_page    out  8  user memory read page
//  mem_rd_offset  out  8  user memory read offset
//  mem_rd_data    in   8  read data, valid exactly 1 clk after mem_rd_en
//  tx_byte        out  8  byte to UART transmitter
//  tx_valid       out  1  tx_byte valid
//  tx_ready       in   1  transmitter accepts; transfer = tx_valid & tx_ready
//  busy           out  1  frame in progress
//  req_drop       out  1  1-cycle pulse: a trigger was discarded
//  frame_done     out  1  1-cycle pulse: checksum byte accepted
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE. Reset mid-frame aborts the frame; no frame_done; no resume.
//  Frame layout: SYNC, TYPE, PAGE, OFFSET, LEN, DATA[0..LEN-1], CSUM.
//   - Block-read response: LEN = data_len.
//   - Write acknowledge: LEN = 8'h00, no DATA bytes; PAGE/OFFSET echo the sampled inputs.
//   - CSUM = two's complement of the 8-bit sum of TYPE..last DATA (SYNC excluded).
//     Sum of TYPE..CSUM mod 256 == 0.
//  FSM: IDLE -> HDR -> (RD -> WAIT)* -> CSUM -> IDLE.
//   IDLE:  on tx_blkrd or tx_blkwr, latch type/page/offset/len.
//          busy=1 from the next cycle until the cycle after frame_done.
//   HDR:   presents header bytes 0..4 in order, one per handshake; then:
//          - RD if block-read and LEN>0;
//          - else CSUM.
//   RD:    mem_rd_en=1 for exactly 1 clk; mem_rd_page=latched page;
//          mem_rd_offset=latched offset+i (8-bit wrap, page never increments).
//   WAIT:  registers mem_rd_data into tx_byte, tx_valid=1, holds until accepted; then:
//          - RD if i<LEN-1;
//          - else CSUM.
//   CSUM:  presents checksum; on acceptance frame_done=1 and return to IDLE.
//  Handshake:
//   - tx_byte stable and tx_valid held while tx_ready=0.
//   - tx_valid never drops before acceptance.
//   - Back-to-back header bytes allowed (next byte valid the cycle after acceptance).
//   - Exactly one mem_rd_en per data byte; never reissued during backpressure.
//  Boundary cases:
//   - Trigger while busy: ignored, req_drop=1 for that cycle; current frame unaffected.
//   - tx_blkrd and tx_blkwr in the same IDLE cycle: read served, write dropped with req_drop.
//   - data_len=0 block-read: header + CSUM only; no mem_rd_en.
//   - data_len=255: 255 reads; offset wraps modulo 256.
//  Latency: trigger at cycle T -> tx_valid with SYNC at T+1.
// TESTING
//  1 blkrd pg=03 off=10 len=02, mem[03:10]=11, [03:11]=22, tx_ready=1
//    -> A5 02 03 10 02 11 22 B6; frame_done once.
//  2 blkwr pg=01 off=20 len=04 -> A5 10 01 20 00 CF; no mem_rd_en.
//  3 case 1 with tx_ready=0 for 5 clks while DATA[0] presented
//    -> tx_byte=11 held stable, single mem_rd_en for off 10, output bytes identical.
//  4 blkrd pg=07 off=FE len=03 -> reads at 07:FE, 07:FF, 07:00; CSUM correct.
//  5 tx_blkwr pulse during case 1 frame -> req_drop 1 clk, frame unchanged.
//    Simultaneous blkrd+blkwr -> read frame emitted, req_drop=1.
//  6 rst_b low mid-DATA -> outputs 0 and busy=0.
//    Then blkrd len=00 pg=00 off=00 -> A5 02 00 00 00 FE.

Source files
------------

// File: rtl/helm_rsp_tx.sv
// Response framer for the helm UART link: builds SYNC/TYPE/PAGE/OFFSET/LEN/DATA/CSUM
// frames for block-read responses and write acknowledges and streams them byte by byte.
module helm_rsp_tx #(
    parameter logic [7:0] C_SYNC         = 8'hA5,
    parameter logic [7:0] C_RSP_BLK_READ = 8'h02,
    parameter logic [7:0] C_RSP_WR_ACK   = 8'h10
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       tx_blkrd,
    input  logic       tx_blkwr,
    input  logic [7:0] data_len,
    input  logic [7:0] usr_mem_page,
    input  logic [7:0] usr_mem_offset,
    output logic       mem_rd_en,
    output logic [7:0] mem_rd_page,
    output logic [7:0] mem_rd_offset,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       req_drop,
    output logic       frame_done
);

    // Byte interface: a byte moves when tx_valid & tx_ready at a rising edge; tx_valid and
    // tx_byte hold unchanged until that happens, and tx_valid never drops before it does.
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_WAIT, S_CSUM} state_t;

    state_t     state_q;
    logic       is_rd_q;
    logic [7:0] page_q;
    logic [7:0] off_q;
    logic [7:0] len_q;
    logic [7:0] idx_q;
    logic [2:0] hdr_q;
    logic [7:0] sum_q;
    logic       busy_q;
    logic       frame_done_q;
    logic       mem_rd_en_q;
    logic [7:0] mem_rd_page_q;
    logic [7:0] mem_rd_offset_q;
    logic [7:0] tx_byte_q;
    logic       tx_valid_q;

    logic       can_start_d;
    logic       start_d;
    logic       xfer_d;
    logic [7:0] type_d;
    logic [7:0] len_d;
    logic [7:0] hdr_next_d;
    logic [7:0] csum_d;

    assign can_start_d = (state_q == S_IDLE) && !busy_q;
    assign start_d     = can_start_d && (tx_blkrd || tx_blkwr);
    assign xfer_d      = tx_valid_q && tx_ready;
    // Read wins a simultaneous trigger, so the write is the one reported as dropped.
    assign req_drop    = (!can_start_d && (tx_blkrd || tx_blkwr)) ||
                         (can_start_d && tx_blkrd && tx_blkwr);
    assign type_d      = tx_blkrd ? C_RSP_BLK_READ : C_RSP_WR_ACK;
    assign len_d       = tx_blkrd ? data_len : 8'h00;
    assign csum_d      = 8'h00 - sum_q;

    always_comb begin
        hdr_next_d = len_q;
        case (hdr_q)
            3'd0:    hdr_next_d = is_rd_q ? C_RSP_BLK_READ : C_RSP_WR_ACK;
            3'd1:    hdr_next_d = page_q;
            3'd2:    hdr_next_d = off_q;
            default: hdr_next_d = len_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q         <= S_IDLE;
            is_rd_q         <= 1'b0;
            page_q          <= 8'h00;
            off_q           <= 8'h00;
            len_q           <= 8'h00;
            idx_q           <= 8'h00;
            hdr_q           <= 3'd0;
            sum_q           <= 8'h00;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            mem_rd_en_q     <= 1'b0;
            mem_rd_page_q   <= 8'h00;
            mem_rd_offset_q <= 8'h00;
            tx_byte_q       <= 8'h00;
            tx_valid_q      <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            if (frame_done_q) busy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        is_rd_q    <= tx_blkrd;
                        page_q     <= usr_mem_page;
                        off_q      <= usr_mem_offset;
                        len_q      <= len_d;
                        sum_q      <= type_d + usr_mem_page + usr_mem_offset + len_d;
                        hdr_q      <= 3'd0;
                        idx_q      <= 8'h00;
                        tx_byte_q  <= C_SYNC;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (xfer_d) begin
                        if (hdr_q != 3'd4) begin
                            hdr_q     <= hdr_q + 3'd1;
                            tx_byte_q <= hdr_next_d;
                        end else if (is_rd_q && (len_q != 8'h00)) begin
                            tx_valid_q      <= 1'b0;
                            mem_rd_en_q     <= 1'b1;
                            mem_rd_page_q   <= page_q;
                            mem_rd_offset_q <= off_q;
                            state_q         <= S_RD;
                        end else begin
                            tx_byte_q <= csum_d;
                            state_q   <= S_CSUM;
                        end
                    end
                end
                S_RD: state_q <= S_WAIT;
                S_WAIT: begin
                    // First WAIT cycle is when the memory's registered read data is valid.
                    if (!tx_valid_q) begin
                        tx_byte_q  <= mem_rd_data;
                        tx_valid_q <= 1'b1;
                        sum_q      <= sum_q + mem_rd_data;
                    end else if (xfer_d) begin
                        if (idx_q != (len_q - 8'h01)) begin
                            idx_q           <= idx_q + 8'h01;
                            tx_valid_q      <= 1'b0;
                            mem_rd_en_q     <= 1'b1;
                            mem_rd_offset_q <= off_q + idx_q + 8'h01;
                            state_q         <= S_RD;
                        end else begin
                            tx_byte_q <= csum_d;
                            state_q   <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer_d) begin
                        tx_valid_q   <= 1'b0;
                        tx_byte_q    <= 8'h00;
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en     = mem_rd_en_q;
    assign mem_rd_page   = mem_rd_page_q;
    assign mem_rd_offset = mem_rd_offset_q;
    assign tx_byte       = tx_byte_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

endmodule
